bcd_mod_counter: RTL

Parametrised BCD modulo-N counter, the generalised successor to the clock's fixed hour counter. One instance per clock field (seconds, minutes, hours, or any custom modulus). Counts up or down on a carry-in, accepts manual adjust from a push key and a parallel BCD load, and emits a one-cycle carry/borrow pulse to chain the next stage.

---
 rtl/bcd_mod_counter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bcd_mod_counter.sv
// Parametrised BCD modulo-N up/down counter with carry-in, manual push-key adjust,
// validated parallel load and a registered carry/borrow pulse for chaining stages.
module bcd_mod_counter #(
   parameter int unsigned MODULUS = 24,
   parameter int unsigned DIGITS  = 2,
   parameter int unsigned START   = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                dir,
   input  logic                key,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   output logic [4*DIGITS-1:0] out,
   output logic                en_out,
   output logic                load_err
);

   localparam int unsigned W = 4 * DIGITS;

   typedef logic [W-1:0] bcd_t;

   function automatic bcd_t to_bcd(input int unsigned v);
      bcd_t        r;
      int unsigned x;
      r = '0;
      x = v;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x           = x / 10;
      end
      return r;
   endfunction

   function automatic bcd_t bcd_inc(input bcd_t v);
      bcd_t r;
      logic carry;
      r     = v;
      carry = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic bcd_t bcd_dec(input bcd_t v);
      bcd_t r;
      logic borrow;
      r      = v;
      borrow = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   localparam bcd_t BcdMax   = to_bcd(MODULUS - 1);
   localparam bcd_t BcdStart = to_bcd(START);

   logic        key_s1, key_s2, key_s3;
   logic        key_fall;
   logic        step;
   logic        wrap;
   bcd_t        step_val;
   logic        load_ok;
   int unsigned load_bin;
   logic [3:0]  digit;

   assign key_fall = key_s3 & ~key_s2;
   assign step     = en | key_fall;

   always_comb begin
      wrap     = dir ? (out == BcdMax) : (out == '0);
      step_val = '0;
      if (dir) begin
         step_val = wrap ? '0 : bcd_inc(out);
      end else begin
         step_val = wrap ? BcdMax : bcd_dec(out);
      end
   end

   // Load is accepted only if every digit is decimal and the value is in range.
   always_comb begin
      load_ok  = 1'b1;
      load_bin = 0;
      digit    = 4'd0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         digit    = load_val[4*(DIGITS-1-i) +: 4];
         if (digit > 4'd9) load_ok = 1'b0;
         load_bin = load_bin * 10 + 32'(digit);
      end
      if (load_bin >= MODULUS) load_ok = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out      <= BcdStart;
         en_out   <= 1'b0;
         load_err <= 1'b0;
         key_s1   <= 1'b1;
         key_s2   <= 1'b1;
         key_s3   <= 1'b1;
      end else begin
         key_s1   <= key;
         key_s2   <= key_s1;
         key_s3   <= key_s2;
         en_out   <= 1'b0;
         load_err <= 1'b0;
         if (load) begin
            if (load_ok) out <= load_val;
            else         load_err <= 1'b1;
         end else if (step) begin
            out    <= step_val;
            // Key-only wraps must not ripple into the next field.
            en_out <= en & wrap;
         end
      end
   end

endmodule
